// File: rtl/alu_rs_pkg.sv
// Shared sizes, ALU opcodes and entry types for the ALU reservation station.
// The snoop helper is the single place where operand capture from the buses is defined.
package alu_rs_pkg;

    localparam int RS_DEPTH = 4;
    localparam int TAG_W    = 4;
    localparam int OP_W     = 4;
    localparam int DATA_W   = 32;
    localparam int IDX_W    = $clog2(RS_DEPTH);

    localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [OP_W-1:0] ALU_SLL = 4'd5;
    localparam logic [OP_W-1:0] ALU_SRL = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRA = 4'd7;
    localparam logic [OP_W-1:0] ALU_LT  = 4'd8;
    localparam logic [OP_W-1:0] ALU_LTU = 4'd9;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic              qj_valid;
        logic [TAG_W-1:0]  qj;
        logic              qk_valid;
        logic [TAG_W-1:0]  qk;
        logic [TAG_W-1:0]  tag;
    } rs_entry_t;

    typedef struct packed {
        logic              pending;
        logic [TAG_W-1:0]  q;
        logic [DATA_W-1:0] v;
    } operand_t;

    // Bus A (own result) wins over bus B (external CDB) if both ever match.
    function automatic operand_t snoop(
        input operand_t          o,
        input logic              a_vld,
        input logic [TAG_W-1:0]  a_tag,
        input logic [DATA_W-1:0] a_val,
        input logic              b_vld,
        input logic [TAG_W-1:0]  b_tag,
        input logic [DATA_W-1:0] b_val
    );
        operand_t r;
        r = o;
        if (o.pending && a_vld && (o.q == a_tag)) begin
            r.pending = 1'b0;
            r.v       = a_val;
        end else if (o.pending && b_vld && (o.q == b_tag)) begin
            r.pending = 1'b0;
            r.v       = b_val;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index pickers: first free entry for dispatch and first ready entry for issue.
module alu_rs_pick
    import alu_rs_pkg::*;
(
    input  logic [RS_DEPTH-1:0] i_busy,
    input  logic [RS_DEPTH-1:0] i_rdy,
    output logic [IDX_W-1:0]    o_free_idx,
    output logic                o_free_any,
    output logic [IDX_W-1:0]    o_rdy_idx,
    output logic                o_rdy_any
);

    // Scanning downward leaves the lowest matching index as the final winner.
    always_comb begin
        o_free_idx = '0;
        o_free_any = 1'b0;
        o_rdy_idx  = '0;
        o_rdy_any  = 1'b0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!i_busy[i]) begin
                o_free_idx = IDX_W'(i);
                o_free_any = 1'b1;
            end
            if (i_rdy[i]) begin
                o_rdy_idx = IDX_W'(i);
                o_rdy_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, snoops result/CDB buses for operands,
// issues the lowest-index ready entry and tags the ALU result one edge later.
module alu_rs
    import alu_rs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              disp_valid,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [DATA_W-1:0] disp_vj,
    input  logic [DATA_W-1:0] disp_vk,
    input  logic              disp_qj_valid,
    input  logic [TAG_W-1:0]  disp_qj,
    input  logic              disp_qk_valid,
    input  logic [TAG_W-1:0]  disp_qk,
    input  logic [TAG_W-1:0]  disp_tag,
    output logic              rs_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    output logic              alu_enable,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_value_1,
    output logic [DATA_W-1:0] alu_value_2,
    input  logic              alu_ready,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    output logic [TAG_W-1:0]  res_tag,
    output logic [DATA_W-1:0] res_value
);

    // Handshakes: a dispatch is taken at the edge where disp_valid=1 and rs_full=0
    // (rs_full is the only back-pressure); alu_enable is a one-cycle strobe with no
    // back-pressure, answered by alu_ready exactly one edge later.
    rs_entry_t             r_ent     [RS_DEPTH];
    rs_entry_t             w_ent_nxt [RS_DEPTH];
    logic [RS_DEPTH-1:0]   w_busy;
    logic [RS_DEPTH-1:0]   w_rdy;
    logic [IDX_W-1:0]      w_free_idx;
    logic [IDX_W-1:0]      w_rdy_idx;
    logic                  w_free_any;
    logic                  w_rdy_any;
    logic                  w_disp_fire;
    logic                  r_alu_enable;
    logic [OP_W-1:0]       r_alu_op;
    logic [DATA_W-1:0]     r_alu_value_1;
    logic [DATA_W-1:0]     r_alu_value_2;
    logic                  r_v1;
    logic                  r_v2;
    logic [TAG_W-1:0]      r_tag_q1;
    logic [TAG_W-1:0]      r_tag_q2;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_busy[i] = r_ent[i].busy;
            w_rdy[i]  = r_ent[i].busy && !r_ent[i].qj_valid && !r_ent[i].qk_valid;
        end
    end

    alu_rs_pick u_pick (
        .i_busy     (w_busy),
        .i_rdy      (w_rdy),
        .o_free_idx (w_free_idx),
        .o_free_any (w_free_any),
        .o_rdy_idx  (w_rdy_idx),
        .o_rdy_any  (w_rdy_any)
    );

    assign rs_full     = &w_busy;
    assign w_disp_fire = disp_valid && w_free_any;
    assign res_valid   = alu_ready && r_v2;
    assign res_tag     = r_tag_q2;
    assign res_value   = alu_result;
    assign alu_enable  = r_alu_enable;
    assign alu_op      = r_alu_op;
    assign alu_value_1 = r_alu_value_1;
    assign alu_value_2 = r_alu_value_2;

    // Wakeup, issue-clear and dispatch touch distinct entries, so applying them in order is safe.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_ent_nxt[i] = r_ent[i];
            {w_ent_nxt[i].qj_valid, w_ent_nxt[i].qj, w_ent_nxt[i].vj} =
                snoop({r_ent[i].qj_valid, r_ent[i].qj, r_ent[i].vj},
                      res_valid, res_tag, res_value, cdb_valid, cdb_tag, cdb_value);
            {w_ent_nxt[i].qk_valid, w_ent_nxt[i].qk, w_ent_nxt[i].vk} =
                snoop({r_ent[i].qk_valid, r_ent[i].qk, r_ent[i].vk},
                      res_valid, res_tag, res_value, cdb_valid, cdb_tag, cdb_value);
            if (w_rdy_any && (w_rdy_idx == IDX_W'(i))) begin
                w_ent_nxt[i].busy = 1'b0;
            end
            if (w_disp_fire && (w_free_idx == IDX_W'(i))) begin
                w_ent_nxt[i].busy = 1'b1;
                w_ent_nxt[i].op   = disp_op;
                w_ent_nxt[i].tag  = disp_tag;
                {w_ent_nxt[i].qj_valid, w_ent_nxt[i].qj, w_ent_nxt[i].vj} =
                    snoop({disp_qj_valid, disp_qj, disp_vj},
                          res_valid, res_tag, res_value, cdb_valid, cdb_tag, cdb_value);
                {w_ent_nxt[i].qk_valid, w_ent_nxt[i].qk, w_ent_nxt[i].vk} =
                    snoop({disp_qk_valid, disp_qk, disp_vk},
                          res_valid, res_tag, res_value, cdb_valid, cdb_tag, cdb_value);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_ent[i] <= w_ent_nxt[i];
                if (flush) begin
                    r_ent[i].busy <= 1'b0;
                end
            end
        end
    end

    // Clearing v1/v2 on flush discards whatever the ALU returns for squashed ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_enable  <= 1'b0;
            r_alu_op      <= '0;
            r_alu_value_1 <= '0;
            r_alu_value_2 <= '0;
            r_v1          <= 1'b0;
            r_v2          <= 1'b0;
            r_tag_q1      <= '0;
            r_tag_q2      <= '0;
        end else if (flush) begin
            r_alu_enable <= 1'b0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
        end else begin
            r_alu_enable <= w_rdy_any;
            r_v1         <= w_rdy_any;
            r_v2         <= r_v1;
            r_tag_q2     <= r_tag_q1;
            if (w_rdy_any) begin
                r_alu_op      <= r_ent[w_rdy_idx].op;
                r_alu_value_1 <= r_ent[w_rdy_idx].vj;
                r_alu_value_2 <= r_ent[w_rdy_idx].vk;
                r_tag_q1      <= r_ent[w_rdy_idx].tag;
            end
        end
    end

endmodule
